// File: rtl/decam_pkg.sv
// Shared sizes and state encoding for the DeCam key sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package decam_pkg;

   localparam int NCAM  = 6;
   localparam int NPI   = 36;
   localparam int NPO   = 7;
   localparam int KEY_W = 2 * NCAM;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_RESP,
      ST_SW_SETTLE,
      ST_SW_DONE
   } state_e;

endpackage

// File: rtl/decam_key_shreg.sv
// Serial key shadow register plus the active key that drives the core selects.
// Latency: a commit shows on active_key one cycle later; each shift lands one cycle later.
// Backpressure: none; shifts always land, and commits are dropped unless commit_en is high.
module decam_key_shreg
   import decam_pkg::*;
#(
   parameter int KW = KEY_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          key_sdi,
   input  logic          key_shift,
   input  logic          key_commit,
   input  logic          commit_en,
   output logic [KW-1:0] active_key
);

   logic [KW-1:0] shadow;

   // Shift new bits in from the top so the first bit of a full key ends at bit 0;
   // a same-cycle commit sees the pre-shift shadow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow     <= '0;
         active_key <= '0;
      end else begin
         if (key_shift) begin
            shadow <= {key_sdi, shadow[KW-1:1]};
         end
         if (key_commit && commit_en) begin
            active_key <= shadow;
         end
      end
   end

endmodule

// File: rtl/decam_key_sequencer.sv
// Drives one camouflaged core: serial key load, handshaked vector tests, and exhaustive key sweep.
// Latency: response SETTLE cycles after accept; a sweep captures key k at (k+1)*SETTLE cycles after start.
// Backpressure: req_ready low whenever busy; a response is held until resp_ready, and a sweep is never stalled.
module decam_key_sequencer
   import decam_pkg::*;
#(
   parameter int NCAM   = decam_pkg::NCAM,
   parameter int NPI    = decam_pkg::NPI,
   parameter int NPO    = decam_pkg::NPO,
   parameter int SETTLE = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              key_sdi,
   input  logic              key_shift,
   input  logic              key_commit,
   output logic [2*NCAM-1:0] s_out,
   output logic [NPI-1:0]    pi_out,
   input  logic [NPO-1:0]    po_in,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [NPI-1:0]    req_pi,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [NPO-1:0]    resp_po,
   input  logic              sweep_start,
   input  logic [NPI-1:0]    sweep_pi,
   input  logic [NPO-1:0]    sweep_golden,
   output logic              sweep_done,
   output logic              sweep_hit,
   output logic [2*NCAM-1:0] sweep_key,
   output logic              busy
);

   localparam int KW = 2 * NCAM;
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt;
   logic [KW-1:0]   sw_cnt;
   logic [NPO-1:0]  golden_q;
   logic [KW-1:0]   active_key;
   logic            cnt_zero;
   logic            sw_match;
   logic            sw_last;

   assign cnt_zero = (cnt == '0);
   assign sw_match = (po_in == golden_q);
   assign sw_last  = (sw_cnt == {KW{1'b1}});

   decam_key_shreg #(
      .KW(KW)
   ) u_shreg (
      .clk        (clk),
      .rst        (rst),
      .key_sdi    (key_sdi),
      .key_shift  (key_shift),
      .key_commit (key_commit),
      .commit_en  (state_q == ST_IDLE),
      .active_key (active_key)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a sweep start wins over a pending request.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (sweep_start) begin
               state_d = ST_SW_SETTLE;
            end else if (req_valid) begin
               state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_zero) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (resp_ready) begin
               state_d = ST_IDLE;
            end
         end
         ST_SW_SETTLE: begin
            if (cnt_zero && (sw_match || sw_last)) begin
               state_d = ST_SW_DONE;
            end
         end
         ST_SW_DONE: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Outputs decoded from state; the core sees the sweep key only while a sweep is settling.
   always_comb begin
      req_ready  = (state_q == ST_IDLE) && !sweep_start;
      resp_valid = (state_q == ST_RESP);
      sweep_done = (state_q == ST_SW_DONE);
      busy       = (state_q != ST_IDLE);
      s_out      = (state_q == ST_SW_SETTLE) ? sw_cnt : active_key;
   end

   // Datapath: vector drive, settle counter, capture, and sweep key enumeration.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         pi_out    <= '0;
         resp_po   <= '0;
         golden_q  <= '0;
         sw_cnt    <= '0;
         sweep_hit <= 1'b0;
         sweep_key <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (sweep_start) begin
                  pi_out    <= sweep_pi;
                  golden_q  <= sweep_golden;
                  sw_cnt    <= '0;
                  sweep_hit <= 1'b0;
                  cnt       <= CNT_LOAD;
               end else if (req_valid) begin
                  pi_out <= req_pi;
                  cnt    <= CNT_LOAD;
               end
            end
            ST_SETTLE: begin
               if (cnt_zero) begin
                  resp_po <= po_in;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            ST_SW_SETTLE: begin
               if (cnt_zero) begin
                  if (sw_match) begin
                     sweep_hit <= 1'b1;
                     sweep_key <= sw_cnt;
                  end else if (sw_last) begin
                     sweep_key <= {KW{1'b1}};
                  end else begin
                     sw_cnt <= sw_cnt + KW'(1);
                     cnt    <= CNT_LOAD;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_decam_key_sequencer.sv
// Directed plus randomized bench for decam_key_sequencer with a behavioural core stub and key model.
// Latency: n/a.
// Backpressure: n/a.
module tb_decam_key_sequencer;

   localparam int S  = 2;
   localparam int KW = 12;

   logic          clk = 1'b0;
   logic          rst;
   logic          key_sdi, key_shift, key_commit;
   logic [KW-1:0] s_out;
   logic [35:0]   pi_out;
   logic [6:0]    po_in;
   logic          req_valid, req_ready;
   logic [35:0]   req_pi;
   logic          resp_valid, resp_ready;
   logic [6:0]    resp_po;
   logic          sweep_start;
   logic [35:0]   sweep_pi;
   logic [6:0]    sweep_golden;
   logic          sweep_done, sweep_hit;
   logic [KW-1:0] sweep_key;
   logic          busy;

   int checks = 0;
   int errors = 0;

   // core stub configuration
   int         stub_mode = 0;
   logic [11:0] stub_tgt = '0;
   logic [6:0] stub_hit_po = '0, stub_miss_po = '0, stub_fixed = '0;

   // reference model state
   bit          key_hist[$];
   logic [11:0] active_m = '0;

   decam_key_sequencer #(.NCAM(6), .NPI(36), .NPO(7), .SETTLE(S)) dut (
      .clk(clk), .rst(rst), .key_sdi(key_sdi), .key_shift(key_shift), .key_commit(key_commit),
      .s_out(s_out), .pi_out(pi_out), .po_in(po_in),
      .req_valid(req_valid), .req_ready(req_ready), .req_pi(req_pi),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_po(resp_po),
      .sweep_start(sweep_start), .sweep_pi(sweep_pi), .sweep_golden(sweep_golden),
      .sweep_done(sweep_done), .sweep_hit(sweep_hit), .sweep_key(sweep_key), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] core_fn(logic [35:0] pi, logic [11:0] key);
      case (stub_mode)
         0:       return pi[6:0] ^ pi[35:29] ^ key[6:0] ^ key[11:5];
         1:       return (key == stub_tgt) ? stub_hit_po : stub_miss_po;
         default: return stub_fixed;
      endcase
   endfunction

   always_comb po_in = core_fn(pi_out, s_out);

   // last twelve bits shifted in, earliest of them at bit 0
   function automatic logic [11:0] model_shadow();
      logic [11:0] k;
      k = '0;
      for (int i = 0; i < 12; i++) begin
         int idx;
         idx = key_hist.size() - 12 + i;
         if (idx >= 0) k[i] = key_hist[idx];
      end
      return k;
   endfunction

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic shift_key(logic [11:0] v);
      for (int i = 0; i < 12; i++) begin
         key_sdi   = v[i];
         key_shift = 1'b1;
         key_hist.push_back(v[i]);
         tick();
      end
      key_shift = 1'b0;
   endtask

   task automatic do_req(logic [35:0] pi, int hold);
      logic [6:0] exp_po;
      exp_po    = core_fn(pi, active_m);
      req_pi    = pi;
      req_valid = 1'b1;
      #1;
      check("req_ready_idle", 64'(req_ready), 64'(1));
      tick();
      req_valid = 1'b0;
      check("pi_out", 64'(pi_out), 64'(pi));
      check("busy_settle", 64'(busy), 64'(1));
      check("resp_valid_early", 64'(resp_valid), 64'(0));
      for (int i = 1; i < S; i++) begin
         tick();
         check("resp_valid_settle", 64'(resp_valid), 64'(0));
      end
      tick();
      check("resp_valid", 64'(resp_valid), 64'(1));
      check("resp_po", 64'(resp_po), 64'(exp_po));
      for (int i = 0; i < hold; i++) begin
         tick();
         check("resp_hold_valid", 64'(resp_valid), 64'(1));
         check("resp_hold_po", 64'(resp_po), 64'(exp_po));
         check("req_ready_resp", 64'(req_ready), 64'(0));
      end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check("resp_valid_drop", 64'(resp_valid), 64'(0));
      check("req_ready_back", 64'(req_ready), 64'(1));
   endtask

   task automatic run_sweep(logic [35:0] pi, logic [6:0] gold, bit with_req);
      bit          exp_hit, done;
      logic [11:0] exp_key;
      int          exp_edges, m;
      exp_hit = 1'b0;
      exp_key = 12'hFFF;
      for (int k = 0; k < 4096; k++) begin
         if (core_fn(pi, 12'(k)) == gold) begin
            exp_hit = 1'b1;
            exp_key = 12'(k);
            break;
         end
      end
      exp_edges    = (int'(exp_key) + 1) * S;
      sweep_pi     = pi;
      sweep_golden = gold;
      sweep_start  = 1'b1;
      req_valid    = with_req;
      req_pi       = ~pi;
      #1;
      check("req_ready_sweep_start", 64'(req_ready), 64'(0));
      tick();
      sweep_start = 1'b0;
      req_valid   = 1'b0;
      check("sweep_busy", 64'(busy), 64'(1));
      check("sweep_s_out0", 64'(s_out), 64'(0));
      check("sweep_pi_out", 64'(pi_out), 64'(pi));
      check("sweep_hit_clr", 64'(sweep_hit), 64'(0));
      m    = 0;
      done = 1'b0;
      while (!done && m < 4096 * S + 16) begin
         tick();
         m++;
         if (m == 3 * S + 1 && m < exp_edges) check("sweep_s_out_mid", 64'(s_out), 64'(3));
         if (sweep_done) done = 1'b1;
      end
      check("sweep_timeout", 64'(done), 64'(1));
      check("sweep_len", 64'(m), 64'(exp_edges));
      check("sweep_hit", 64'(sweep_hit), 64'(exp_hit));
      check("sweep_key", 64'(sweep_key), 64'(exp_key));
      check("sweep_s_out_restore", 64'(s_out), 64'(active_m));
      check("resp_valid_sweep", 64'(resp_valid), 64'(0));
      tick();
      check("sweep_done_pulse", 64'(sweep_done), 64'(0));
      check("sweep_idle", 64'(busy), 64'(0));
      check("sweep_hit_hold", 64'(sweep_hit), 64'(exp_hit));
      check("sweep_key_hold", 64'(sweep_key), 64'(exp_key));
   endtask

   task automatic check_reset_vals(string where);
      check({where, "_busy"}, 64'(busy), 64'(0));
      check({where, "_s_out"}, 64'(s_out), 64'(0));
      check({where, "_pi_out"}, 64'(pi_out), 64'(0));
      check({where, "_resp_po"}, 64'(resp_po), 64'(0));
      check({where, "_resp_valid"}, 64'(resp_valid), 64'(0));
      check({where, "_sweep_done"}, 64'(sweep_done), 64'(0));
      check({where, "_sweep_hit"}, 64'(sweep_hit), 64'(0));
      check({where, "_sweep_key"}, 64'(sweep_key), 64'(0));
   endtask

   initial begin
      logic [35:0] rpi;
      logic [11:0] rkey;
      rst = 1'b1;
      key_sdi = 0; key_shift = 0; key_commit = 0;
      req_valid = 0; req_pi = '0; resp_ready = 0;
      sweep_start = 0; sweep_pi = '0; sweep_golden = '0;
      #3;
      check_reset_vals("por");
      rst = 1'b0;
      #1;
      check("req_ready_after_por", 64'(req_ready), 64'(1));
      tick();

      // key load and commit
      shift_key(12'h9B3);
      key_commit = 1'b1;
      active_m   = model_shadow();
      tick();
      key_commit = 1'b0;
      check("commit_9b3", 64'(s_out), 64'(active_m));
      check("commit_9b3_abs", 64'(s_out), 64'(12'h9B3));

      // fixed core output request, response held three cycles
      stub_mode  = 2;
      stub_fixed = 7'h2A;
      do_req(36'h1, 3);

      // commit while busy is ignored; shadow still updates
      stub_mode = 0;
      req_pi    = 36'h123456789;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      shift_key(12'h5A5);
      key_commit = 1'b1;
      tick();
      key_commit = 1'b0;
      check("commit_busy_ignored", 64'(s_out), 64'(active_m));
      check("resp_pending", 64'(resp_valid), 64'(1));
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      tick();
      check("no_queued_commit", 64'(s_out), 64'(active_m));
      // shift and commit together: commit takes the pre-shift shadow
      key_sdi    = 1'b1;
      key_shift  = 1'b1;
      key_commit = 1'b1;
      active_m   = model_shadow();
      key_hist.push_back(1'b1);
      tick();
      key_shift  = 1'b0;
      key_commit = 1'b0;
      check("commit_preshift", 64'(s_out), 64'(active_m));

      // random requests against the xor core stub
      for (int n = 0; n < 6; n++) begin
         rpi = {4'($urandom()), $urandom()};
         if (n % 2 == 1) begin
            rkey = 12'($urandom());
            shift_key(rkey);
            key_commit = 1'b1;
            active_m   = model_shadow();
            tick();
            key_commit = 1'b0;
            check("commit_rand", 64'(s_out), 64'(active_m));
         end
         do_req(rpi, int'($urandom_range(0, 3)));
      end

      // sweep collides with a request; sweep wins
      stub_mode    = 1;
      stub_tgt     = 12'($urandom_range(4, 300));
      stub_hit_po  = 7'($urandom_range(1, 127));
      stub_miss_po = stub_hit_po ^ 7'h1;
      run_sweep({4'($urandom()), $urandom()}, stub_hit_po, 1'b1);

      // random sweeps against the xor core stub
      stub_mode = 0;
      for (int n = 0; n < 2; n++) begin
         run_sweep({4'($urandom()), $urandom()}, 7'($urandom()), 1'b0);
      end

      // known hit at 0x9B3
      stub_mode    = 1;
      stub_tgt     = 12'h9B3;
      stub_hit_po  = 7'h55;
      stub_miss_po = 7'h00;
      run_sweep(36'h0F0F0F0F0, 7'h55, 1'b0);

      // never matched
      stub_mode  = 2;
      stub_fixed = 7'h00;
      run_sweep(36'h1, 7'h7F, 1'b0);

      // reset mid-sweep
      sweep_pi     = 36'h3;
      sweep_golden = 7'h7F;
      sweep_start  = 1'b1;
      tick();
      sweep_start = 1'b0;
      repeat (10) tick();
      check("mid_sweep_busy", 64'(busy), 64'(1));
      #2;
      rst = 1'b1;
      #1;
      check_reset_vals("rst_sweep");
      key_hist.delete();
      active_m = '0;
      rst = 1'b0;
      #1;
      check("req_ready_after_rst_sweep", 64'(req_ready), 64'(1));
      tick();

      // reset while a response is pending
      stub_fixed = 7'h33;
      req_pi     = 36'hABC;
      req_valid  = 1'b1;
      tick();
      req_valid = 1'b0;
      repeat (S) tick();
      check("resp_before_rst", 64'(resp_valid), 64'(1));
      check("resp_po_before_rst", 64'(resp_po), 64'(7'h33));
      #2;
      rst = 1'b1;
      #1;
      check_reset_vals("rst_resp");
      rst = 1'b0;
      #1;
      check("req_ready_after_rst_resp", 64'(req_ready), 64'(1));
      tick();
      check("idle_after_rst_resp", 64'(busy), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/decam_key_sequencer.md
# decam_key_sequencer

Sequential controller that configures and drives one camouflaged combinational core, such as the 6-gate randCam c432 variant. The core has 36 primary inputs, 7 primary outputs and 12 select bits, `s_0`..`s_11`, grouped as 6 pairs, where every pair value 00..11 is allowed. The block loads the select key serially and applies test vectors through a valid/ready handshake. It waits a fixed settle time before capturing the core outputs. It also has a sweep mode that enumerates all 4^6 keys against one vector and golden response, acting as the oracle-query engine for DeCam incremental-SAT experiments.

## Interface
Parameters:
- `NCAM`, default 6: number of camouflaged gates; key width is 2*NCAM.
- `NPI`, default 36: core primary-input width.
- `NPO`, default 7: core primary-output width.
- `SETTLE`, default 2: cycles from driving the core to capturing it; must be ≥1.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `key_sdi`  in  1  serial key bit.
- `key_shift`  in  1  shift `key_sdi` into the shadow register this cycle.
- `key_commit`  in  1  copy shadow to active key; honoured only in IDLE.
- `s_out`  out  2*NCAM  select bits to the core; bit i drives `s_i`.
- `pi_out`  out  NPI  vector to the core.
- `po_in`  in  NPO  core outputs.
- `req_valid`, `req_ready`  in/out  1  vector request handshake.
- `req_pi`  in  NPI  request vector.
- `resp_valid`, `resp_ready`  out/in  1  response handshake.
- `resp_po`  out  NPO  captured outputs.
- `sweep_start`  in  1  start key enumeration (IDLE only).
- `sweep_pi`  in  NPI  sweep vector, sampled at start.
- `sweep_golden`  in  NPO  expected outputs, sampled at start.
- `sweep_done`  out  1  one-cycle pulse at end of sweep.
- `sweep_hit`  out  1  a matching key was found.
- `sweep_key`  out  2*NCAM  first matching key, or last key tried.
- `busy`  out  1  state ≠ IDLE.

## Operation
- Shadow shift: when `key_shift`=1, shadow ← {key_sdi, shadow[2N-1:1]}. After 12 shifts, the first bit shifted in sits at bit 0 (`s_0`). Shifting is legal in any state.
- Commit: `key_commit` in IDLE sets active ← shadow, visible on `s_out` the next cycle. In other states it is ignored and not queued. Shifting and committing in the same cycle commits the pre-shift shadow.
- States: IDLE, SETTLE, RESP, SW_SETTLE, SW_DONE.
- IDLE: `req_ready` = (state==IDLE) && !sweep_start. `sweep_start` has priority over `req_valid`.
- Request accept (`req_valid`&&`req_ready`):
  - `pi_out` ← `req_pi`; cnt ← SETTLE-1; go to SETTLE.
  - SETTLE: if cnt==0, `resp_po` ← `po_in` and go to RESP; otherwise decrement cnt.
- RESP: `resp_valid`=1 and `resp_po` holds stable until `resp_valid`&&`resp_ready`, then return to IDLE.
- Sweep start:
  - Latch `sweep_pi` and `sweep_golden`; sweep key ← 0; `s_out` shows the sweep key; clear `sweep_hit`.
  - SW_SETTLE: at the capture edge (cnt==0), compare `po_in` with golden.
    - Match: `sweep_hit` ← 1, `sweep_key` ← key, go to SW_DONE.
    - Key = all-ones without a match: `sweep_key` ← all-ones, go to SW_DONE.
    - Otherwise: key+1, cnt ← SETTLE-1, stay in SW_SETTLE.
- SW_DONE: `sweep_done`=1 for exactly one cycle, then IDLE. `s_out` reverts to the active key. `sweep_hit` and `sweep_key` hold until the next `sweep_start`.
- Key counter is 2*NCAM bits and never wraps; the all-ones check ends the sweep.

## Timing
- Reset (async): state IDLE, shadow=0, active=0, `s_out`=0, `pi_out`=0, `resp_po`=0, `resp_valid`=0, `sweep_done`=0, `sweep_hit`=0, `sweep_key`=0, `busy`=0. `req_ready`=1 once reset is released.
- Request accepted at edge T: `pi_out` is valid after T, the capture edge is T+SETTLE, and `resp_valid` is high from T+SETTLE. Minimum request-to-request spacing is SETTLE+1 cycles.
- Sweep started at edge T: key k is captured at edge T+(k+1)·SETTLE. `sweep_done` is high during the cycle after the final capture edge.
- Worst case (no hit): 4096·SETTLE cycles plus 1.
- Reset mid-operation: all of the above values are restored immediately, any pending response is lost, and `resp_valid` drops asynchronously.

## Structure
- Package `decam_pkg` holds `NCAM`, `NPI`, `NPO`, the key-width localparam, and the `state_e` enum.
- Sub-module `decam_key_shreg` contains the shadow shift register, the active key register and the commit logic. Top-level muxes `s_out` between the active key and the sweep key.

## Test plan
- Shift key 0x9B3 LSB-first, commit in IDLE → `s_out`=0x9B3 on the next cycle. Commit while busy → `s_out` unchanged.
- SETTLE=2, request `req_pi`=36'h1, core stub drives `po_in`=7'h2A → `resp_valid` 2 cycles after accept with `resp_po`=0x2A. Hold `resp_ready`=0 for 3 cycles → output stable, `req_ready`=0 throughout.
- `sweep_start` and `req_valid` in the same cycle → sweep runs, request not accepted (`req_ready`=0).
- Stub `po_in` = (s_out==0x9B3) ? 7'h55 : 0, golden 0x55 → `sweep_done` after 2484·2 cycles, `sweep_hit`=1, `sweep_key`=0x9B3, `s_out` restored.
- Golden 7'h7F, never matched → `sweep_done` after 8192 cycles, `sweep_hit`=0, `sweep_key`=0xFFF.
- Assert `rst` mid-sweep and in RESP → outputs reach reset values without a clock edge, and `req_ready`=1 after release.
